// File: rtl/uart_transmitter.sv
// Unpacks FIFO words into back-to-back 8N1 UART frames, most-significant byte first.
// Optional even-parity bit per frame when UART_TX_PARITY_EN is defined (8E1).
module uart_transmitter #(
    parameter int unsigned UART_BPS      = 1_500_000,
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned FIFO_RD_WIDTH = 32,
    parameter int unsigned FIFO_RD_BYTE  = FIFO_RD_WIDTH >> 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
    output logic                     fifo_rd_en,
    output logic                     tx,
    output logic                     busy
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int unsigned BYTE_IDX_W   = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [BAUD_W-1:0]        baud_cnt;
    logic [2:0]               bit_cnt;
    logic [BYTE_IDX_W-1:0]    byte_idx;
    logic [FIFO_RD_WIDTH-1:0] word_reg;
    logic [7:0]               cur_byte;
    logic                     in_bit;
    logic                     bit_end;
    logic                     last_byte;

    // The byte on the line is always the top byte; the word shifts left between frames.
    assign cur_byte  = word_reg[FIFO_RD_WIDTH-1 -: 8];
    assign bit_end   = in_bit && (baud_cnt == BAUD_W'(BAUD_CNT_MAX - 1));
    assign last_byte = (byte_idx == BYTE_IDX_W'(FIFO_RD_BYTE - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        tx         = 1'b1;
        busy       = (state != S_IDLE);
        in_bit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                fifo_rd_en = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = S_START;
            end
            S_START: begin
                in_bit = 1'b1;
                tx     = 1'b0;
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_bit = 1'b1;
                tx     = cur_byte[bit_cnt];
                if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                in_bit = 1'b1;
                tx     = ^cur_byte;
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                in_bit = 1'b1;
                if (bit_end) begin
                    state_next = last_byte ? S_IDLE : S_START;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Baud, bit and byte counters plus the word register
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            word_reg <= '0;
        end else begin
            if (!in_bit || bit_end || (state_next != state)) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            if (state != S_DATA) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == S_LOAD) begin
                word_reg <= fifo_rd_data;
                byte_idx <= '0;
            end else if ((state == S_STOP) && bit_end && !last_byte) begin
                word_reg <= word_reg << 8;
                byte_idx <= byte_idx + BYTE_IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a FIFO model feeds words, the TX line is logged per cycle
// and compared against a waveform built from the frame rules (8N1, or 8E1 with UART_TX_PARITY_EN).
module tb_uart_transmitter;

    localparam int unsigned W  = 32;
    localparam int unsigned NB = 4;
    localparam int unsigned B  = 66;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif
    localparam int unsigned L    = NB * FB * B;
    localparam int          LOGN = 65536;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_rd_data = '0;
    logic         fifo_rd_en;
    logic         tx;
    logic         busy;

    uart_transmitter dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fifo_mem [16];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    bit           toggle_en = 1'b0;

    logic         tx_log   [LOGN];
    logic         busy_log [LOGN];
    logic         rd_log   [LOGN];
    logic         emp_log  [LOGN];
    int           rd_q [$];
    int           ncyc = 0;

    // FIFO model (data valid the cycle after the read) and per-cycle line recorder
    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1 && rd_ptr != wr_ptr) begin
            fifo_rd_data = fifo_mem[rd_ptr % 16];
            rd_ptr++;
        end
        if (toggle_en) fifo_empty = ~fifo_empty;
        else           fifo_empty = (rd_ptr == wr_ptr);
        tx_log[ncyc]   = tx;
        busy_log[ncyc] = busy;
        rd_log[ncyc]   = fifo_rd_en;
        emp_log[ncyc]  = fifo_empty;
        if (fifo_rd_en === 1'b1) rd_q.push_back(ncyc);
        if (ncyc < LOGN - 1) ncyc++;
    end

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_mem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    function automatic int count_rd(input int from);
        int n = 0;
        foreach (rd_q[i]) if (rd_q[i] >= from) n++;
        return n;
    endfunction

    function automatic int find_fall(input int from);
        for (int i = from; i < ncyc; i++) if (emp_log[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input logic [W-1:0] w, input int by);
        return 8'(w >> (8 * (NB - 1 - by)));
    endfunction

    // Compare the logged line against the words in exp_q, sent back to back from the first empty fall
    task automatic check_words(input string tag, input int from);
        int         t0;
        int         nw;
        int         span;
        int         wi, r, f, by, bt, k;
        int         tx_err, busy_err, first_err, nrd;
        logic       exp_tx, exp_busy;
        logic [7:0] bv, dec;
        nw = exp_q.size();
        t0 = find_fall(from);
        span = nw * int'(L + 3) + 40;
        chk({tag, " word start seen"}, 32'(t0 >= 0 && t0 + span < ncyc), 32'(1));
        if (t0 < 0 || t0 + span >= ncyc) return;
        nrd = 0;
        foreach (rd_q[i]) begin
            if (rd_q[i] >= from) begin
                if (nrd < nw) chk({tag, " rd_en timing"}, 32'(rd_q[i] - t0), 32'(1 + nrd * int'(L + 3)));
                nrd++;
            end
        end
        chk({tag, " rd_en count"}, 32'(nrd), 32'(nw));
        tx_err = 0; busy_err = 0; first_err = -1;
        for (int o = 0; o < span; o++) begin
            exp_tx = 1'b1;
            exp_busy = 1'b0;
            wi = o / int'(L + 3);
            r  = o % int'(L + 3);
            if (wi < nw) begin
                if (r >= 1) exp_busy = 1'b1;
                if (r >= 3) begin
                    f  = r - 3;
                    by = f / int'(FB * B);
                    bt = (f % int'(FB * B)) / int'(B);
                    bv = byte_of(exp_q[wi], by);
                    if (bt == 0)      exp_tx = 1'b0;
                    else if (bt <= 8) exp_tx = bv[bt-1];
`ifdef UART_TX_PARITY_EN
                    else if (bt == 9) exp_tx = ^bv;
`endif
                end
            end
            if (tx_log[t0 + o] !== exp_tx) begin
                tx_err++;
                if (first_err < 0) first_err = o;
            end
            if (busy_log[t0 + o] !== exp_busy) busy_err++;
        end
        chk({tag, " tx waveform errors"}, 32'(tx_err), 32'(0));
        if (first_err >= 0) $display("  first tx divergence at offset %0d", first_err);
        chk({tag, " busy waveform errors"}, 32'(busy_err), 32'(0));
        // Independent mid-bit decode of every byte
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < int'(NB); b++) begin
                k = t0 + 3 + w * int'(L + 3) + b * int'(FB * B);
                dec = '0;
                for (int d = 0; d < 8; d++) dec[d] = tx_log[k + (d + 1) * int'(B) + int'(B) / 2];
                chk({tag, $sformatf(" decoded byte w%0d b%0d", w, b)}, 32'(dec), 32'(byte_of(exp_q[w], b)));
            end
        end
    endtask

    initial begin
        int           from, t0, target, errs;
        logic [W-1:0] w;
        logic [7:0]   bv;

        // Reset state
        cycles(3);
        chk("reset tx", 32'(tx), 32'(1));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset rd_en", 32'(fifo_rd_en), 32'(0));
        rst = 1'b0;

        // Empty FIFO for 1000 cycles: line idle
        from = ncyc;
        cycles(1000);
        errs = 0;
        for (int i = from; i < ncyc; i++)
            if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0 || rd_log[i] !== 1'b0) errs++;
        chk("idle line errors", 32'(errs), 32'(0));
        chk("idle rd_en count", 32'(count_rd(from)), 32'(0));

        // Single known word
        from = ncyc;
        exp_q = {32'hA1B2_C3D4};
        push(32'hA1B2_C3D4);
        cycles(int'(L) + 100);
        check_words("single", from);

        // Two preloaded words, all-zero and all-one
        from = ncyc;
        exp_q = {32'h0000_0000, 32'hFFFF_FFFF};
        push(32'h0000_0000);
        push(32'hFFFF_FFFF);
        cycles(2 * int'(L) + 100);
        check_words("pair", from);

        // Reset in the middle of data bit 3 of the second byte
        from = ncyc;
        w = W'($urandom);
        push(w);
        cycles(2);
        t0 = find_fall(from);
        chk("reset-test start seen", 32'(t0 >= 0), 32'(1));
        target = t0 + 3 + int'(FB * B) + 4 * int'(B) + int'(B) / 2;
        for (int g = 0; g < 2000 && ncyc <= target; g++) cycles(1);
        bv = byte_of(w, 1);
        chk("pre-reset data bit", 32'(tx), 32'(bv[3]));
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("post-reset tx", 32'(tx), 32'(1));
        chk("post-reset busy", 32'(busy), 32'(0));
        chk("post-reset rd_en", 32'(fifo_rd_en), 32'(0));
        cycles(500);
        chk("post-reset rd_en count", 32'(count_rd(from)), 32'(1));
        chk("post-reset line idle", 32'(tx), 32'(1));

        from = ncyc;
        w = W'($urandom);
        exp_q = {w};
        push(w);
        cycles(int'(L) + 100);
        check_words("after reset", from);

        // fifo_empty toggling every cycle while a word is on the line
        from = ncyc;
        w = W'($urandom);
        exp_q = {w};
        push(w);
        cycles(4);
        toggle_en = 1'b1;
        cycles(int'(L) - 100);
        toggle_en = 1'b0;
        cycles(200);
        check_words("empty toggle", from);

        // Random back-to-back words
        from = ncyc;
        exp_q = {};
        for (int i = 0; i < 3; i++) begin
            w = W'($urandom);
            exp_q.push_back(w);
            push(w);
        end
        cycles(3 * int'(L) + 100);
        check_words("random burst", from);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
